// File: rtl/axi_mcast_fork_ctrl.sv
// Per-slave-port AW/W fork controller. An AW is reserved on every targeted
// master-port mux and committed only once all of them have granted; the
// committed target mask is queued so W beats are replicated in lockstep to
// the same port set.

// One master-port lane: AW reservation request/hit and W beat request/hit.
module axi_mcast_fork_lane (
    input  logic aw_en,
    input  logic sel,
    input  logic acc,
    input  logic mcast,
    input  logic aw_rdy,
    input  logic w_en,
    input  logic head,
    input  logic sent,
    input  logic w_rdy,
    output logic aw_valid,
    output logic aw_hit,
    output logic is_mcast,
    output logic w_valid,
    output logic w_hit
);
    // A lane that already reserved (or took the beat) drops valid and waits.
    assign aw_valid = aw_en & sel & ~acc;
    assign aw_hit   = acc | (sel & aw_rdy & aw_valid);
    assign is_mcast = aw_valid & mcast;
    assign w_valid  = w_en & head & ~sent;
    assign w_hit    = sent | (head & w_rdy & w_valid);
endmodule

module axi_mcast_fork_ctrl #(
    parameter int NoMstPorts = 4,
    parameter int MaxWTrans  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  aw_valid_i,
    output logic                  aw_ready_o,
    input  logic [NoMstPorts-1:0] aw_select_i,
    input  logic                  aw_is_mcast_i,
    output logic [NoMstPorts-1:0] mst_aw_valid_o,
    input  logic [NoMstPorts-1:0] mst_aw_ready_i,
    output logic [NoMstPorts-1:0] mst_is_mcast_o,
    output logic [NoMstPorts-1:0] mst_aw_commit_o,
    input  logic                  w_valid_i,
    input  logic                  w_last_i,
    output logic                  w_ready_o,
    output logic [NoMstPorts-1:0] mst_w_valid_o,
    input  logic [NoMstPorts-1:0] mst_w_ready_i,
    output logic                  busy_o
);
    localparam int CW = $clog2(MaxWTrans) + 1;
    localparam int PW = (MaxWTrans > 1) ? $clog2(MaxWTrans) : 1;

    typedef enum logic {IDLE, COLLECT} state_e;

    state_e                  state_q, state_d;
    logic [NoMstPorts-1:0]   aw_acc_q, aw_acc_d;
    logic [NoMstPorts-1:0]   w_sent_q, w_sent_d;
    logic [MaxWTrans-1:0][NoMstPorts-1:0] mask_mem;
    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic [CW-1:0]           cnt;

    logic                    full, empty, aw_en, w_en, aw_done, w_done, push, pop;
    logic [NoMstPorts-1:0]   aw_hit, w_hit, head;

    assign full  = (cnt == CW'(MaxWTrans));
    assign empty = (cnt == '0);
    assign head  = mask_mem[rd_ptr];

    // Outputs are held quiet while reset is asserted, even if upstream keeps
    // presenting traffic. An all-zero select is never issued.
    assign aw_en = rst_ni & aw_valid_i & ~full & (|aw_select_i);
    assign w_en  = rst_ni & w_valid_i & ~empty;

    for (genvar p = 0; p < NoMstPorts; p++) begin : g_lane
        axi_mcast_fork_lane u_lane (
            .aw_en    (aw_en),
            .sel      (aw_select_i[p]),
            .acc      (aw_acc_q[p]),
            .mcast    (aw_is_mcast_i),
            .aw_rdy   (mst_aw_ready_i[p]),
            .w_en     (w_en),
            .head     (head[p]),
            .sent     (w_sent_q[p]),
            .w_rdy    (mst_w_ready_i[p]),
            .aw_valid (mst_aw_valid_o[p]),
            .aw_hit   (aw_hit[p]),
            .is_mcast (mst_is_mcast_o[p]),
            .w_valid  (mst_w_valid_o[p]),
            .w_hit    (w_hit[p])
        );
    end

    // Commit/accept only when every targeted port has reserved; same for W beats.
    assign aw_done         = aw_en & (aw_hit == aw_select_i);
    assign aw_ready_o      = aw_done;
    assign mst_aw_commit_o = aw_done ? aw_select_i : '0;
    assign push            = aw_done;
    assign w_done          = w_en & (w_hit == head);
    assign w_ready_o       = w_done;
    assign pop             = w_done & w_last_i;
    assign busy_o          = (state_q != IDLE) | ~empty;

    // Multicast reservation FSM: accumulate grants until the whole mask is held.
    always_comb begin
        state_d  = state_q;
        aw_acc_d = aw_acc_q;
        w_sent_d = w_sent_q;
        if (aw_done) begin
            state_d  = IDLE;
            aw_acc_d = '0;
        end else if (aw_en && aw_is_mcast_i) begin
            state_d  = COLLECT;
            aw_acc_d = aw_hit;
        end
        if (w_done)    w_sent_d = '0;
        else if (w_en) w_sent_d = w_hit;
    end

    // FSM, reservation and beat-tracking state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            aw_acc_q <= '0;
            w_sent_q <= '0;
        end else begin
            state_q  <= state_d;
            aw_acc_q <= aw_acc_d;
            w_sent_q <= w_sent_d;
        end
    end

    // Mask FIFO pointers and occupancy; push legality already used pre-pop full.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PW'(MaxWTrans - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == PW'(MaxWTrans - 1)) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Mask storage; contents are don't-care while not counted.
    always_ff @(posedge clk_i) begin
        if (push) mask_mem[wr_ptr] <= aw_select_i;
    end

    a_sel_nonzero: assert property (@(posedge clk_i) disable iff (!rst_ni)
        aw_valid_i |-> (|aw_select_i));
    a_ucast_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (aw_valid_i && !aw_is_mcast_i) |-> $onehot(aw_select_i));
    a_collect_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == COLLECT) |-> ($stable(aw_select_i) && $stable(aw_is_mcast_i)));
    a_commit_subset: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (mst_aw_commit_o & ~aw_select_i) == '0);
endmodule

// File: tb/tb_axi_mcast_fork_ctrl.sv
// Directed bench with an AW/W scoreboard: stimulus queues expected commits
// and beats (mask + cycle), a negedge monitor pops and compares them.
module tb_axi_mcast_fork_ctrl;
    logic       clk = 1'b0;
    logic       rst_ni;
    logic       aw_valid, aw_ready, aw_mcast, w_valid, w_last, w_ready, busy;
    logic [3:0] aw_sel, m_aw_valid, m_aw_ready, m_is_mcast, m_commit, m_w_valid, m_w_ready;

    typedef struct {logic [3:0] mask; int cyc;} exp_t;
    exp_t aw_q[$];
    exp_t w_q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [3:0] wacc = '0;

    axi_mcast_fork_ctrl #(.NoMstPorts(4), .MaxWTrans(2)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_select_i(aw_sel),
        .aw_is_mcast_i(aw_mcast), .mst_aw_valid_o(m_aw_valid), .mst_aw_ready_i(m_aw_ready),
        .mst_is_mcast_o(m_is_mcast), .mst_aw_commit_o(m_commit),
        .w_valid_i(w_valid), .w_last_i(w_last), .w_ready_o(w_ready),
        .mst_w_valid_o(m_w_valid), .mst_w_ready_i(m_w_ready), .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] outs();
        return {13'd0, aw_ready, m_aw_valid, m_is_mcast, m_commit, w_ready, m_w_valid, busy};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every AW commit and every accepted W beat must match
    // the next queued expectation, including the cycle it happens in.
    always @(negedge clk) begin : mon
        exp_t e;
        logic [3:0] hs;
        hs = m_w_valid & m_w_ready;
        if (!rst_ni) wacc = '0;
        if (aw_ready || m_commit != 4'b0) begin
            if (aw_q.size() == 0) chk("aw_unexpected", {aw_ready, m_commit}, 0);
            else begin
                e = aw_q.pop_front();
                chk("aw_commit", m_commit, e.mask);
                chk("aw_ready", aw_ready, 1);
                chk("aw_cycle", cyc, e.cyc);
            end
        end
        if ((hs & wacc) != 4'b0) chk("w_dup_beat", hs & wacc, 0);
        if (w_ready) begin
            if (w_q.size() == 0) chk("w_unexpected", w_ready, 0);
            else begin
                e = w_q.pop_front();
                chk("w_ports", wacc | hs, e.mask);
                chk("w_cycle", cyc, e.cyc);
            end
            wacc = '0;
        end else begin
            wacc = wacc | hs;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: timeout at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst_ni = 1'b0;
        aw_valid = 1'b1; aw_sel = 4'b0001; aw_mcast = 1'b0; m_aw_ready = 4'b1111;
        w_valid = 1'b1; w_last = 1'b0; m_w_ready = 4'b1111;
        @(negedge clk);
        chk("reset_outs", outs(), 0);
        tick(); tick();
        aw_valid = 1'b0; aw_sel = '0; m_aw_ready = '0; w_valid = 1'b0; m_w_ready = '0;
        rst_ni = 1'b1;
        @(negedge clk);
        chk("idle_outs", outs(), 0);
        tick();

        // 1: unicast to port 2, zero-cycle commit, 3-beat burst from next cycle
        aw_valid = 1'b1; aw_sel = 4'b0100; aw_mcast = 1'b0; m_aw_ready = 4'b0100;
        w_valid = 1'b1; w_last = 1'b0; m_w_ready = 4'b1111;
        aw_q.push_back('{4'b0100, cyc});
        @(negedge clk);
        chk("t1_aw_valid", m_aw_valid, 4'b0100);
        chk("t1_w_empty", m_w_valid, 4'b0000);
        tick();
        aw_valid = 1'b0; m_aw_ready = '0;
        w_q.push_back('{4'b0100, cyc});
        @(negedge clk);
        chk("t1_w_valid", m_w_valid, 4'b0100);
        tick();
        w_q.push_back('{4'b0100, cyc}); tick();
        w_last = 1'b1; w_q.push_back('{4'b0100, cyc}); tick();
        w_valid = 1'b0; w_last = 1'b0;
        @(negedge clk);
        chk("t1_busy", busy, 0);
        tick();

        // 2: multicast 1011, ports 0/1 grant in cycle 0, port 3 in cycle 2
        aw_valid = 1'b1; aw_sel = 4'b1011; aw_mcast = 1'b1; m_aw_ready = 4'b0011;
        @(negedge clk);
        chk("t2_c0_valid", m_aw_valid, 4'b1011);
        chk("t2_c0_mcast", m_is_mcast, 4'b1011);
        tick();
        m_aw_ready = 4'b0000;
        @(negedge clk);
        chk("t2_c1_valid", m_aw_valid, 4'b1000);
        tick();
        m_aw_ready = 4'b1000;
        aw_q.push_back('{4'b1011, cyc});
        @(negedge clk);
        chk("t2_c2_valid", m_aw_valid, 4'b1000);
        tick();
        aw_valid = 1'b0; aw_mcast = 1'b0; m_aw_ready = '0;
        w_valid = 1'b1; w_last = 1'b1; m_w_ready = 4'b1111;
        w_q.push_back('{4'b1011, cyc});
        tick();
        w_valid = 1'b0; w_last = 1'b0;
        tick();

        // 3: multicast W to 0011, port 1 stalls two cycles
        aw_valid = 1'b1; aw_sel = 4'b0011; aw_mcast = 1'b1; m_aw_ready = 4'b0011;
        aw_q.push_back('{4'b0011, cyc});
        tick();
        aw_valid = 1'b0; aw_mcast = 1'b0; m_aw_ready = '0;
        w_valid = 1'b1; w_last = 1'b0; m_w_ready = 4'b0001;
        @(negedge clk);
        chk("t3_a_valid", m_w_valid, 4'b0011);
        tick();
        @(negedge clk);
        chk("t3_b_valid", m_w_valid, 4'b0010);
        tick();
        m_w_ready = 4'b0011;
        w_q.push_back('{4'b0011, cyc});
        @(negedge clk);
        chk("t3_c_valid", m_w_valid, 4'b0010);
        tick();
        w_last = 1'b1;
        w_q.push_back('{4'b0011, cyc});
        @(negedge clk);
        chk("t3_d_valid", m_w_valid, 4'b0011);
        tick();
        w_valid = 1'b0; w_last = 1'b0; m_w_ready = '0;
        tick();

        // 4: depth 2, third AW blocked until the cycle after the pop
        aw_valid = 1'b1; aw_sel = 4'b0001; aw_mcast = 1'b0; m_aw_ready = 4'b1111;
        aw_q.push_back('{4'b0001, cyc}); tick();
        aw_sel = 4'b0010;
        aw_q.push_back('{4'b0010, cyc}); tick();
        aw_sel = 4'b0100;
        @(negedge clk);
        chk("t4_full_a", m_aw_valid, 4'b0000);
        chk("t4_busy", busy, 1);
        tick();
        @(negedge clk);
        chk("t4_full_b", m_aw_valid, 4'b0000);
        tick();
        w_valid = 1'b1; w_last = 1'b0; m_w_ready = 4'b1111;
        w_q.push_back('{4'b0001, cyc}); tick();
        w_last = 1'b1;
        w_q.push_back('{4'b0001, cyc});
        aw_q.push_back('{4'b0100, cyc + 1});
        @(negedge clk);
        chk("t4_prepop", m_aw_valid, 4'b0000);
        tick();
        w_valid = 1'b0; w_last = 1'b0;
        @(negedge clk);
        chk("t4_issue", m_aw_valid, 4'b0100);
        tick();

        // 6: FIFO full (0010,0100); mcast then unicast with last-beat pops
        aw_sel = 4'b1001; aw_mcast = 1'b1;
        w_valid = 1'b1; w_last = 1'b1;
        w_q.push_back('{4'b0010, cyc});
        @(negedge clk);
        chk("t6_full_wait", m_aw_valid, 4'b0000);
        tick();
        aw_q.push_back('{4'b1001, cyc});
        w_q.push_back('{4'b0100, cyc});
        tick();
        aw_sel = 4'b1000; aw_mcast = 1'b0;
        aw_q.push_back('{4'b1000, cyc});
        w_q.push_back('{4'b1001, cyc});
        tick();
        aw_valid = 1'b0; m_aw_ready = '0;
        w_q.push_back('{4'b1000, cyc});
        @(negedge clk);
        chk("t6_busy_hi", busy, 1);
        tick();
        w_valid = 1'b0; w_last = 1'b0;
        @(negedge clk);
        chk("t6_drained", busy, 0);
        tick();

        // 5: reset while collecting with aw_acc=0001 and a queued mask
        aw_valid = 1'b1; aw_sel = 4'b0001; aw_mcast = 1'b0; m_aw_ready = 4'b1111;
        aw_q.push_back('{4'b0001, cyc}); tick();
        aw_sel = 4'b0011; aw_mcast = 1'b1; m_aw_ready = 4'b0001; tick();
        m_aw_ready = 4'b0000;
        @(negedge clk);
        chk("t5_collect", m_aw_valid, 4'b0010);
        chk("t5_busy_hi", busy, 1);
        tick();
        rst_ni = 1'b0; m_aw_ready = 4'b1111; w_valid = 1'b1; m_w_ready = 4'b1111;
        @(negedge clk);
        chk("t5_rst_outs", outs(), 0);
        tick();
        rst_ni = 1'b1; aw_valid = 1'b0; aw_sel = '0; aw_mcast = 1'b0; m_aw_ready = '0;
        @(negedge clk);
        chk("t5_fifo_empty", m_w_valid, 4'b0000);
        chk("t5_busy", busy, 0);
        tick();
        w_valid = 1'b0; m_w_ready = '0;
        repeat (3) tick();

        chk("aw_q_left", aw_q.size(), 0);
        chk("w_q_left", w_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
